// File: rtl/bypass_rf_pkg.sv
// bypass_rf_pkg: shared widths and FSM encoding for the bypass register-file client
package bypass_rf_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NAME_WIDTH = 2;
  typedef enum logic [1:0] {IDLE, RES, WAIT, OUT} state_t;
endpackage

// File: rtl/bypass_rf_client.sv
// bypass_rf_client: in-order operand fetch and writeback client for a renaming bypass register file
module bypass_rf_client
  import bypass_rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int NAME_W = NAME_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_rs1,
  input  logic [ADDR_W-1:0] i_req_rs2,
  input  logic [ADDR_W-1:0] i_req_rd,
  input  logic              i_req_wr,
  output logic              o_op_valid,
  input  logic              i_op_ready,
  output logic [DATA_W-1:0] o_op_d1,
  output logic [DATA_W-1:0] o_op_d2,
  input  logic              i_wb_valid,
  output logic              o_wb_ready,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [ADDR_W-1:0] o_rf_addr_in,
  output logic              o_rf_alloc_e,
  input  logic              i_rf_alloc_ready,
  input  logic [NAME_W-1:0] i_rf_name_out,
  output logic [ADDR_W-1:0] o_rf_addr_1,
  output logic [ADDR_W-1:0] o_rf_addr_2,
  output logic              o_rf_rrese_1,
  output logic              o_rf_rrese_2,
  input  logic              i_rf_rres_ready_1,
  input  logic              i_rf_rres_ready_2,
  input  logic [DATA_W-1:0] i_rf_d_out_1,
  input  logic [DATA_W-1:0] i_rf_d_out_2,
  input  logic              i_rf_valid_out_1,
  input  logic              i_rf_valid_out_2,
  output logic              o_rf_fe_1,
  output logic              o_rf_fe_2,
  output logic [NAME_W-1:0] o_rf_name_in_1,
  output logic [NAME_W-1:0] o_rf_w_f,
  output logic [DATA_W-1:0] o_rf_d_in_1,
  output logic              o_rf_we_1,
  output logic              o_rf_wfe,
  input  logic              i_rf_f_ready
);
  localparam int NUM_NAMES = 2**NAME_W;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_rs1, r_rs2, r_rd;
  logic              r_wr;
  logic [DATA_W-1:0] r_d1, r_d2;
  logic [NAME_W:0]   r_out;
  logic [NAME_W-1:0] r_wb_name, r_alloc_name;
  logic              w_accept, w_go, w_alloc, w_cap, w_xfer, w_wb;
  // Every strobe is gated by reset so nothing leaks out while state is being cleared.
  assign o_req_ready = !i_rst && r_state == IDLE;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_go        = !i_rst && r_state == RES && i_rf_rres_ready_1 && i_rf_rres_ready_2 &&
                       (i_rf_alloc_ready || !r_wr);
  assign w_alloc     = w_go && r_wr;
  assign w_cap       = !i_rst && r_state == WAIT && i_rf_valid_out_1 && i_rf_valid_out_2;
  assign o_op_valid  = !i_rst && r_state == OUT;
  assign w_xfer      = o_op_valid && i_op_ready;
  assign o_wb_ready  = !i_rst && r_out != '0 && i_rf_f_ready;
  assign w_wb        = i_wb_valid && o_wb_ready;
  assign o_rf_addr_1    = r_rs1;
  assign o_rf_addr_2    = r_rs2;
  assign o_rf_addr_in   = r_rd;
  assign o_rf_rrese_1   = w_go;
  assign o_rf_rrese_2   = w_go;
  assign o_rf_alloc_e   = w_alloc;
  assign o_rf_fe_1      = w_cap;
  assign o_rf_fe_2      = w_cap;
  assign o_op_d1        = r_d1;
  assign o_op_d2        = r_d2;
  assign o_rf_name_in_1 = r_wb_name;
  assign o_rf_w_f       = r_wb_name;
  assign o_rf_d_in_1    = i_wb_data;
  assign o_rf_we_1      = w_wb;
  assign o_rf_wfe       = w_wb;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? RES  : IDLE;
      RES:     w_next = w_go     ? WAIT : RES;
      WAIT:    w_next = w_cap    ? OUT  : WAIT;
      default: w_next = w_xfer   ? IDLE : OUT;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_out        <= '0;
      r_wb_name    <= '0;
      r_alloc_name <= '0;
    end else begin
      r_state <= w_next;
      r_out   <= r_out + (NAME_W+1)'(w_alloc) - (NAME_W+1)'(w_wb);
      if (w_alloc) r_alloc_name <= r_alloc_name + NAME_W'(1);
      if (w_wb) r_wb_name <= r_wb_name + NAME_W'(1);
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_rs1 <= i_req_rs1;
      r_rs2 <= i_req_rs2;
      r_rd  <= i_req_rd;
      r_wr  <= i_req_wr;
    end
    if (w_cap) begin
      r_d1 <= i_rf_d_out_1;
      r_d2 <= i_rf_d_out_2;
    end
  end
  // The file hands out names in the same round-robin order we retire them.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_alloc) assert (i_rf_name_out == r_alloc_name);
    if (!i_rst) assert (r_out <= (NAME_W+1)'(NUM_NAMES));
  end
endmodule

// File: doc/bypass_rf_client.md
BYPASS_RF_CLIENT -- requirements
Module: bypass_rf_client

Interface
REQ-001 Parameters: addr_width 5 (arch reg index); data_width 32; name_width 2 (write-name width, numNames = 2**name_width); all SHALL match the attached register file.
REQ-002 CLK  in  1  sole clock, all state on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 REQ_VALID  in  1  upstream instruction valid.
REQ-005 REQ_READY  out  1  request accepted when REQ_VALID and REQ_READY are both high.
REQ-006 REQ_RS1, REQ_RS2  in  addr_width  source register indices.
REQ-007 REQ_RD  in  addr_width  destination register index.
REQ-008 REQ_WR  in  1  instruction writes REQ_RD.
REQ-009 OP_VALID  out  1  operands available.
REQ-010 OP_READY  in  1  downstream takes operands.
REQ-011 OP_D1, OP_D2  out  data_width  operand values for RS1/RS2.
REQ-012 WB_VALID  in  1  in-order result valid.
REQ-013 WB_READY  out  1  result accepted on WB_VALID and WB_READY.
REQ-014 WB_DATA  in  data_width  result data.
REQ-015 RF_ADDR_IN  out  addr_width  write-reservation address.
REQ-016 RF_ALLOC_E  out  1 / RF_ALLOC_READY  in  1: write-reservation handshake.
REQ-017 RF_NAME_OUT  in  name_width  name granted by an allocation.
REQ-018 RF_ADDR_1, RF_ADDR_2  out  addr_width  read-reservation addresses.
REQ-019 RF_RRESE_1/2  out  1 / RF_RRES_READY_1/2  in  1: read-reservation handshakes.
REQ-020 RF_D_OUT_1/2  in  data_width / RF_VALID_OUT_1/2  in  1: reserved read data and its readiness.
REQ-021 RF_FE_1, RF_FE_2  out  1  release read reservations.
REQ-022 RF_NAME_IN_1, RF_W_F  out  name_width  name being written and freed (always equal).
REQ-023 RF_D_IN_1  out  data_width / RF_WE_1  out  1: write data and write strobe.
REQ-024 RF_WFE  out  1 / RF_F_READY  in  1: free-write handshake.

Function
REQ-025 FSM SHALL have states IDLE, RES, WAIT and OUT; REQ_READY SHALL be 1 only in IDLE; an accepted request latches RS1, RS2, RD and WR and moves to RES.
REQ-026 In RES, RF_ADDR_1/2/IN SHALL drive the latched indices, and go = RRES_READY_1 & RRES_READY_2 & (ALLOC_READY | !WR).
REQ-027 RF_RRESE_1 and RF_RRESE_2 SHALL equal go; RF_ALLOC_E SHALL equal go & WR; all three fire in one cycle so a read never sees its own write; go moves the FSM to WAIT.
REQ-028 When go & WR, outstanding SHALL increment; RF_NAME_OUT SHALL equal expected alloc name, which increments mod numNames (checked by assertion).
REQ-029 In WAIT, when RF_VALID_OUT_1 & RF_VALID_OUT_2, the block SHALL capture RF_D_OUT_1/2 into the OP registers, pulse RF_FE_1/2 for that cycle and move to OUT.
REQ-030 In OUT, OP_VALID=1 with stable OP_D1/D2; OP_READY moves the FSM to IDLE; minimum latency is REQ accept to OP_VALID in 3 cycles.
REQ-031 WB_READY = (outstanding != 0) & RF_F_READY; on a WB transfer, RF_WE_1=RF_WFE=1, RF_NAME_IN_1=RF_W_F=wb_name, RF_D_IN_1=WB_DATA, and wb_name increments mod numNames (wraps 3->0 at name_width 2).
REQ-032 The WB path SHALL be independent of the FSM; alloc and WB in the same cycle leave outstanding unchanged; outstanding (name_width+1 bits) SHALL never exceed numNames, because RF_ALLOC_READY blocks it.
REQ-033 With REQ_WR=0, no allocation occurs and REQ_RD is ignored.

Reset
REQ-034 While RST=1 all RF_* strobes, REQ_READY, OP_VALID and WB_READY SHALL be 0; the next cycle has state IDLE, outstanding 0, wb_name 0, alloc name 0; RST mid-operation abandons the in-flight request (the register file shares RST).

Structure
REQ-035 FSM state encoding (2-bit IDLE/RES/WAIT/OUT) SHALL live in shared package bypass_rf_pkg; no sub-module is used; the block is a single flat module.

Verification
REQ-036 rf[3]=0x11, rf[4]=0x22, REQ rs1=3 rs2=4 rd=5 wr=1, OP_READY=1 -> OP_VALID 3 cycles after accept, OP_D1=0x11, OP_D2=0x22, one alloc addr 5 name 0.
REQ-037 Instr A rd=5, then B rs1=5, A WB=0xAB held 10 cycles -> B OP_VALID stays 0 until the WB cycle+1, then OP_D1=0xAB.
REQ-038 Four write instrs with no WB -> fifth stays in RES with no RRESE/ALLOC_E; it issues the cycle after the first WB.
REQ-039 Nine alloc/WB pairs -> RF_W_F sequence 0,1,2,3,0,1,2,3,0, with outstanding back to 0.
REQ-040 RST pulsed in WAIT -> next cycle REQ_READY=1, OP_VALID=0, WB_READY=0, no RF_FE pulse.
